// File: rtl/dot_acc.sv
// dot_acc: signed dot-product sequencer around a shared multicycle multiplier.
// Define DOT_ACC_SAT_EN for saturating accumulation and the sticky out_sat flag.
module dot_acc #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_valid,
  input  logic             mul_ready,
  input  logic [63:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
`ifdef DOT_ACC_SAT_EN
  output logic             out_sat,
`endif
  output logic [LEN_W-1:0] out_count
);
  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] ISSUE = 4'b0010;
  localparam logic [3:0] WAIT_MUL = 4'b0100;
  localparam logic [3:0] OUT = 4'b1000;
  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_last;
  logic [63:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [63:0]      w_sum;
  logic [63:0]      w_acc_nxt;
  logic             w_ovf;
  logic             w_idle;
  logic             w_issue;
  logic             w_wait;
  logic             w_out;
  assign w_idle  = r_state == IDLE;
  assign w_issue = r_state == ISSUE;
  assign w_wait  = r_state == WAIT_MUL;
  assign w_out   = r_state == OUT;
  assign w_next = w_idle  ? (in_valid ? ISSUE : IDLE) :
                  w_issue ? WAIT_MUL :
                  w_wait  ? (mul_ready ? (r_last ? OUT : IDLE) : WAIT_MUL) :
                  w_out   ? (out_ready ? IDLE : OUT) : IDLE;
  assign w_sum = r_acc + mul_result;
  // Overflow only when both addends share a sign the result does not.
  assign w_ovf = (r_acc[63] == mul_result[63]) && (w_sum[63] != r_acc[63]);
`ifdef DOT_ACC_SAT_EN
  logic r_sat;
  assign w_acc_nxt = w_ovf ? (r_acc[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF) : w_sum;
  assign out_sat = r_sat;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sat <= 1'b0;
    else if (w_wait && mul_ready) r_sat <= r_sat | w_ovf;
    else if (w_out && out_ready) r_sat <= 1'b0;
`else
  logic w_unused;
  assign w_unused = w_ovf;
  assign w_acc_nxt = w_sum;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_last  <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && in_valid) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_last <= in_last;
      end
      if (w_wait && mul_ready) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
      end else if (w_out && out_ready) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end
  assign in_ready  = w_idle;
  assign mul_valid = w_issue;
  assign out_valid = w_out;
  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
endmodule

// File: tb/tb_dot_acc.sv
// tb_dot_acc: directed checks of dot_acc against a behavioural multiplier.
module tb_dot_acc;
  localparam int LW = 3;
  localparam int LAT = 6;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 0, spur = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic in_ready, mul_valid, out_valid, m_rdy;
  logic [31:0] mul_a, mul_b;
  logic [63:0] out_sum, m_res, m_p, mul_result;
  logic [LW-1:0] out_count;
  logic mul_ready;
  int m_cnt, mul_pulses;
  bit m_busy;
  int checks = 0, errors = 0;
`ifdef DOT_ACC_SAT_EN
  logic out_sat;
`endif
  always #5 clk = ~clk;
  assign mul_ready  = m_rdy | spur;
  assign mul_result = spur ? 64'd999 : m_res;
  dot_acc #(.LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
    .mul_ready(mul_ready), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef DOT_ACC_SAT_EN
    .out_sat(out_sat),
`endif
    .out_count(out_count)
  );
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 0; m_rdy <= 0; m_cnt <= 0; m_res <= 0; m_p <= 0;
    end else begin
      m_rdy <= 0;
      if (mul_valid) begin
        m_busy <= 1; m_cnt <= LAT;
        m_p <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
      end else if (m_busy) begin
        if (m_cnt == 0) begin m_rdy <= 1; m_res <= m_p; m_busy <= 0; end
        else m_cnt <= m_cnt - 1;
      end
    end
  always @(posedge clk) if (mul_valid) mul_pulses++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_last = last; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
  endtask
  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
  endtask
  task automatic wait_out(input string name, input logic [63:0] s, input logic [LW-1:0] c, input logic sat);
    wait_valid();
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_sum"}, out_sum, s);
    chk({name, "_count"}, 64'(out_count), 64'(c));
`ifdef DOT_ACC_SAT_EN
    chk({name, "_sat"}, 64'(out_sat), 64'(sat));
`else
    if (sat) chk({name, "_nosat"}, 64'(sat), 64'd0);
`endif
    out_ready = 1; @(posedge clk); @(negedge clk); out_ready = 0;
  endtask
  typedef struct {
    logic [31:0] a, b;
    logic last;
    logic [63:0] sum;
    logic [LW-1:0] cnt;
    logic sat;
  } vec_t;
  vec_t tv[8];
  initial begin
    int p0;
    tv[0] = '{32'd3, 32'd4, 0, 64'd0, 3'd0, 0};
    tv[1] = '{-32'sd2, 32'd5, 0, 64'd0, 3'd0, 0};
    tv[2] = '{32'd7, -32'sd1, 1, 64'hFFFF_FFFF_FFFF_FFFB, 3'd3, 0};
    tv[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 64'h3FFF_FFFF_0000_0001, 3'd1, 0};
    tv[4] = '{32'h8000_0000, 32'h8000_0000, 0, 64'd0, 3'd0, 0};
`ifdef DOT_ACC_SAT_EN
    tv[5] = '{32'h8000_0000, 32'h8000_0000, 1, 64'h7FFF_FFFF_FFFF_FFFF, 3'd2, 1};
`else
    tv[5] = '{32'h8000_0000, 32'h8000_0000, 1, 64'h8000_0000_0000_0000, 3'd2, 0};
`endif
    tv[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'd1, 3'd1, 0};
    tv[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 1, 64'hC000_0000_8000_0000, 3'd1, 0};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mul_valid", 64'(mul_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    rst = 0;
    p0 = mul_pulses;
    for (int i = 0; i < 8; i++) begin
      send(tv[i].a, tv[i].b, tv[i].last);
      if (tv[i].last) wait_out($sformatf("vec%0d", i), tv[i].sum, tv[i].cnt, tv[i].sat);
      if (i == 2) chk("mul_pulses", 64'(mul_pulses - p0), 64'd3);
    end
    // Count wraps modulo 2^LW while the sum keeps growing.
    for (int i = 0; i < 9; i++) send(32'd1, 32'd1, i == 8);
    wait_out("wrap", 64'd9, 3'd1, 0);
    send(32'd6, 32'd7, 1);
    wait_valid();
    in_a = 5; in_b = 5; in_last = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", out_sum, 64'd42);
      chk("bp_count", 64'(out_count), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 0;
    wait_out("bp_release", 64'd42, 3'd1, 0);
    send(32'd5, 32'd5, 1);
    wait_out("bp_next", 64'd25, 3'd1, 0);
    send(32'd1, 32'd2, 0);
    send(32'd3, 32'd4, 0);
    send(32'd5, 32'd6, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_count", 64'(out_count), 64'd2);
    chk("pre_rst_sum", out_sum, 64'd14);
    #2 rst = 1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_mul_valid", 64'(mul_valid), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_sum", out_sum, 64'd0);
    chk("arst_out_count", 64'(out_count), 64'd0);
    @(negedge clk) rst = 0;
    send(32'd2, 32'd3, 1);
    wait_out("post_rst", 64'd6, 3'd1, 0);
    send(32'd1, 32'd10, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
    end
    spur = 1;
    @(negedge clk) spur = 0;
    chk("spur_sum", out_sum, 64'd10);
    chk("spur_count", 64'(out_count), 64'd1);
    chk("spur_in_ready", 64'(in_ready), 64'd1);
    chk("spur_out_valid", 64'(out_valid), 64'd0);
    send(32'd1, 32'd1, 1);
    wait_out("spur_next", 64'd11, 3'd2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
